coin_acceptor: RTL and testbench
================================

# coin_acceptor

Front-end stage of the vending machine that turns the two raw coin-slot sensor lines into clean, single-cycle `c5`/`c10` credit pulses for the vending FSM.
- Synchronises and debounces each sensor independently.
- Detects each coin insertion once.
- Paces pulses so the FSM sees at most one coin every `GAP_CYCLES+1` cycles.
- Holds one coin pending and rejects anything it cannot accept.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flops per sensor line, minimum 2.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable samples needed to accept a level change, minimum 1.
- `GAP_CYCLES`, default 2: idle cycles forced after every credit pulse, minimum 1.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `coin5_raw` in 1: asynchronous, bouncy 5-unit slot sensor; high while a coin passes.
- `coin10_raw` in 1: asynchronous, bouncy 10-unit slot sensor.
- `c5` out 1: registered one-cycle 5-unit credit pulse.
- `c10` out 1: registered one-cycle 10-unit credit pulse.
- `reject` out 1: registered one-cycle pulse when a coin is refused; drives the return-flap solenoid.
- `busy` out 1: high when the state is not IDLE or a coin is pending.

## Operation
- Reset (`rst` low, asynchronous):
  - All outputs go to 0.
  - Synchroniser flops, debounced levels, counters and the pending register clear; state goes to IDLE.
- Synchroniser: `SYNC_STAGES`-flop chain per line.
- Debounce, per line, on the synchronised level `s` against the debounced level `d`:
  - Counter clears on any cycle where `s == d`.
  - Otherwise the counter increments; when it reaches `DEBOUNCE_CYCLES`, `d` takes `s` and the counter clears.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`; the counter never wraps.
- Coin event: a rising edge of `d`, lasting one cycle. A falling edge produces no event.
- Simultaneous 5 and 10 events in the same cycle: `reject` pulses once; no credit and nothing pended.
- Output FSM:
  - IDLE:
    - Selects the pending coin if valid, else the new event.
    - Emits that coin on `c5`/`c10` next cycle and enters GAP with `gap_cnt = GAP_CYCLES`.
    - A new event arriving in the same cycle as a pending coin is served is written to pending.
  - GAP:
    - `gap_cnt` decrements each cycle; returns to IDLE on the cycle `gap_cnt` reaches 0.
    - A new event goes to pending if pending is empty, else `reject` pulses.
- `c5`, `c10` and `reject` are mutually exclusive per cycle, except that `reject` may coincide with a credit pulse.
- Reset mid-operation:
  - Pending and in-flight coins are discarded with no `reject`.
  - A sensor held high across reset release is re-debounced from `d = 0` and credited once.

## Timing
- Latency from a clean raw rising edge to the credit pulse: the pulse is high in cycle `SYNC_STAGES+DEBOUNCE_CYCLES+1` after the first sampling edge. This is 19 cycles with defaults.
- Credit pulse width is exactly 1 cycle.
- Minimum spacing between credit pulses is `GAP_CYCLES+1` cycles.
- A pending coin is emitted on the first IDLE cycle, so its pulse follows the previous pulse by exactly `GAP_CYCLES+1` cycles.
- `reject` fires 1 cycle after the offending event.
- `busy` is registered and is valid in the same cycle as the state it reflects.
- There is no back-pressure; the downstream FSM consumes each pulse in the cycle it is high.

## Structure
- Shared package `vending_pkg` holds:
  - `coin_t` enum: `COIN_NONE`, `COIN_5`, `COIN_10`, with 5/10 unit constants.
  - `acc_state_t` enum: `ACC_IDLE`, `ACC_GAP`.
- Sub-module `coin_debounce`, instantiated twice:
  - Parameters: `SYNC_STAGES`, `DEBOUNCE_CYCLES`.
  - Ports: `clk`, `rst`, `raw`, `level`, `rise`.
- Top level holds arbitration, the pending register and the output FSM.

## Test plan
- Clean 5-unit coin: `coin5_raw` high for 40 cycles → `c5` high for exactly 1 cycle, 19 cycles after the rise; no `reject`; `busy` low again after `GAP_CYCLES`.
- Bounce: `coin10_raw` toggles every 3 cycles for 30 cycles, then holds high 20 cycles → exactly one `c10`, 19 cycles after the final rise.
- Back-to-back coins: 5-unit event, then a 10-unit event 1 cycle later → `c5` at T, `c10` at T+3, `busy` high throughout.
- Overflow: three events within the GAP window → first credited, second pended and credited 3 cycles later, third produces `reject` with no credit.
- Simultaneous events: both raws rise on the same cycle with identical bounce → one `reject`, no `c5` or `c10`.
- Reset mid-GAP with a coin pending: assert `rst` low asynchronously → all outputs 0 immediately; no pulses after release; a sensor held high is credited once, 19 cycles after release.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types for the vending machine front end: coin identities, their
// credit values and the coin acceptor output FSM states.
package vending_pkg;

    typedef enum logic [1:0] {
        COIN_NONE = 2'd0,
        COIN_5    = 2'd1,
        COIN_10   = 2'd2
    } coin_t;

    localparam int COIN5_UNITS  = 5;
    localparam int COIN10_UNITS = 10;

    typedef enum logic {
        ACC_IDLE = 1'b0,
        ACC_GAP  = 1'b1
    } acc_state_t;

endpackage

// File: rtl/coin_debounce.sv
// One coin-slot sensor line: synchroniser chain, stable-sample debouncer and
// a one-cycle pulse on every rising edge of the debounced level.
module coin_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   s;

    // Metastability chain; raw enters at bit 0, settled value leaves at the top.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Count consecutive samples that disagree with the debounced level; accept
    // the new level once enough have been seen, flagging a rise when it goes high.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = s;
            cnt_d   = '0;
            rise_d  = s;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Debouncer state and the registered edge pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounces both sensors, arbitrates coin events, keeps one
// coin pending and paces credit pulses with a fixed idle gap after each one.
module coin_acceptor
    import vending_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int GAP_CYCLES      = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic coin5_raw,
    input  logic coin10_raw,
    output logic c5,
    output logic c10,
    output logic reject,
    output logic busy
);

    localparam int GW = $clog2(GAP_CYCLES + 1);

    logic [1:0]    raw_vec;
    logic [1:0]    rise_vec;
    logic [1:0]    level_unused;

    acc_state_t    state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    coin_t         pend_q, pend_d;
    coin_t         ev;
    coin_t         sel;
    logic          both;
    logic          c5_q, c5_d, c10_q, c10_d, reject_q, reject_d, busy_q, busy_d;

    // Bit 0 is the 5-unit line, bit 1 the 10-unit line.
    assign raw_vec = {coin10_raw, coin5_raw};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_line
            coin_debounce #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk  (clk),
                .rst  (rst),
                .raw  (raw_vec[gi]),
                .level(level_unused[gi]),
                .rise (rise_vec[gi])
            );
        end
    endgenerate

    // Arbitration, pending slot and gap pacing; both coins at once is refused.
    always_comb begin
        both     = rise_vec[0] & rise_vec[1];
        ev       = COIN_NONE;
        if (!both && rise_vec[0]) ev = COIN_5;
        if (!both && rise_vec[1]) ev = COIN_10;
        state_d  = state_q;
        gap_d    = gap_q;
        pend_d   = pend_q;
        sel      = COIN_NONE;
        c5_d     = 1'b0;
        c10_d    = 1'b0;
        reject_d = both;
        case (state_q)
            ACC_IDLE: begin
                sel = (pend_q != COIN_NONE) ? pend_q : ev;
                if (sel != COIN_NONE) begin
                    c5_d    = (sel == COIN_5);
                    c10_d   = (sel == COIN_10);
                    state_d = ACC_GAP;
                    gap_d   = GW'(GAP_CYCLES);
                    // Serving the pending coin frees the slot for a new arrival.
                    pend_d  = (pend_q != COIN_NONE) ? ev : COIN_NONE;
                end
            end
            ACC_GAP: begin
                if (gap_q == GW'(1)) begin
                    state_d = ACC_IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
                if (ev != COIN_NONE) begin
                    if (pend_q == COIN_NONE) pend_d = ev;
                    else                     reject_d = 1'b1;
                end
            end
            default: state_d = ACC_IDLE;
        endcase
        busy_d = (state_d != ACC_IDLE) || (pend_d != COIN_NONE);
    end

    // FSM state, pending coin and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ACC_IDLE;
            gap_q    <= '0;
            pend_q   <= COIN_NONE;
            c5_q     <= 1'b0;
            c10_q    <= 1'b0;
            reject_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            pend_q   <= pend_d;
            c5_q     <= c5_d;
            c10_q    <= c10_d;
            reject_q <= reject_d;
            busy_q   <= busy_d;
        end
    end

    assign c5     = c5_q;
    assign c10    = c10_q;
    assign reject = reject_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: a table of coin scenarios checked cycle by
// cycle, plus hand sequences for bounce, reset mid-GAP and pending overflow.
module tb_coin_acceptor;

    logic clk = 1'b0;
    logic rst;
    logic coin5_raw, coin10_raw;
    logic c5, c10, reject, busy;
    logic f5_raw, f10_raw;
    logic fc5, fc10, freject, fbusy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string name;
        int    t5;
        int    len5;
        int    t10;
        int    len10;
        int    e5;
        int    e10;
        int    erej;
        int    blo;
        int    bhi;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    coin_acceptor #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(16),
        .GAP_CYCLES     (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .coin5_raw (coin5_raw),
        .coin10_raw(coin10_raw),
        .c5        (c5),
        .c10       (c10),
        .reject    (reject),
        .busy      (busy)
    );

    // Short debounce and long gap so three events fit inside one GAP window.
    coin_acceptor #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(1),
        .GAP_CYCLES     (8)
    ) dut_fast (
        .clk       (clk),
        .rst       (rst),
        .coin5_raw (f5_raw),
        .coin10_raw(f10_raw),
        .c5        (fc5),
        .c10       (fc10),
        .reject    (freject),
        .busy      (fbusy)
    );

    task automatic chk(input string nm, input string sig, input int p,
                       input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s cycle=%0d got=%0b expected=%0b", nm, sig, p, act, exp);
        end
    endtask

    // Called at a falling edge; inputs for cycle p are applied before rising edge p,
    // outputs are sampled on the falling edge that follows it.
    task automatic run_window(input string nm, input int n,
                              input int t5, input int len5, input int t10, input int len10,
                              input bit bounce, input int e5, input int e10, input int erej,
                              input int blo, input int bhi);
        int errs0;
        errs0 = errors;
        for (int p = 0; p < n; p++) begin
            coin5_raw = (p >= t5) && (p < t5 + len5);
            if (bounce) coin10_raw = (p < 30) ? (((p / 3) % 2) == 0) : (p < 50);
            else        coin10_raw = (p >= t10) && (p < t10 + len10);
            @(posedge clk);
            @(negedge clk);
            chk(nm, "c5",     p, c5,     p == e5);
            chk(nm, "c10",    p, c10,    p == e10);
            chk(nm, "reject", p, reject, p == erej);
            chk(nm, "busy",   p, busy,   (p >= blo) && (p <= bhi));
        end
        $display("scenario %-10s cycles=%0d new_errors=%0d", nm, n, errors - errs0);
    endtask

    initial begin
        // name, t5, len5, t10, len10, e5, e10, erej, busy_lo, busy_hi
        vecs[0] = '{"clean5",   0, 40, -1,  0, 18, -1, -1, 18, 19};
        vecs[1] = '{"clean10", -1,  0,  0, 40, -1, 18, -1, 18, 19};
        vecs[2] = '{"b2b_5_10", 0, 40,  1, 40, 18, 21, -1, 18, 22};
        vecs[3] = '{"b2b_10_5", 1, 40,  0, 40, 21, 18, -1, 18, 22};
        vecs[4] = '{"simul",    0, 40,  0, 40, -1, -1, 18, -1, -2};

        rst = 1'b1;
        coin5_raw = 1'b0;
        coin10_raw = 1'b0;
        f5_raw = 1'b0;
        f10_raw = 1'b0;

        // Asynchronous reset assertion clears every output without a clock edge.
        #2 rst = 1'b0;
        #1;
        chk("reset", "c5",     0, c5,      1'b0);
        chk("reset", "c10",    0, c10,     1'b0);
        chk("reset", "reject", 0, reject,  1'b0);
        chk("reset", "busy",   0, busy,    1'b0);
        chk("reset", "fbusy",  0, fbusy,   1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_window(vecs[i].name, 80, vecs[i].t5, vecs[i].len5, vecs[i].t10, vecs[i].len10,
                       1'b0, vecs[i].e5, vecs[i].e10, vecs[i].erej, vecs[i].blo, vecs[i].bhi);
        end

        // Bouncy 10-unit line: only the final 20-cycle hold is accepted.
        run_window("bounce", 90, -1, 0, -1, 0, 1'b1, -1, 48, -1, 48, 49);

        // 5-unit credited, 10-unit pended, then reset arrives mid-GAP.
        run_window("pre_reset", 20, 0, 40, 1, 200, 1'b0, 18, -1, -1, 18, 22);
        #2 rst = 1'b0;
        #1;
        chk("mid_reset", "c5",     0, c5,     1'b0);
        chk("mid_reset", "c10",    0, c10,    1'b0);
        chk("mid_reset", "reject", 0, reject, 1'b0);
        chk("mid_reset", "busy",   0, busy,   1'b0);
        coin5_raw = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        // Pending 10 is gone; the 10-unit sensor still high is credited once.
        run_window("post_reset", 60, -1, 0, 0, 25, 1'b0, -1, 18, -1, 18, 19);

        // Overflow on the fast instance: c5 at 3, 10 pended and paid at 12,
        // the second 5-unit edge arrives with the slot full and is rejected at 7.
        begin
            int errs0;
            errs0 = errors;
            for (int p = 0; p < 30; p++) begin
                f5_raw  = (p < 2) || (p >= 4 && p < 10);
                f10_raw = (p >= 1) && (p < 10);
                @(posedge clk);
                @(negedge clk);
                chk("overflow", "c5",     p, fc5,     p == 3);
                chk("overflow", "c10",    p, fc10,    p == 12);
                chk("overflow", "reject", p, freject, p == 7);
                chk("overflow", "busy",   p, fbusy,   (p >= 3) && (p <= 19));
            end
            $display("scenario %-10s cycles=30 new_errors=%0d", "overflow", errors - errs0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
